alu_iter_unit: RTL and testbench
================================

# alu_iter_unit

Iterative execution unit that consumes the 4-bit ALU operation code produced by the instruction decoder and computes the result over one or more cycles behind a valid/ready handshake. Add, logic and compare ops complete in one cycle. Shifts run bit-serially, one position per cycle, to save area in the monocycle core's execute stage. It sits between operand selection (register file / immediate mux) and writeback / data-memory address generation.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be a power of two ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.

- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `in_valid_i`  in  1: operands and aluop are presented.
- `in_ready_o`  out  1: unit can accept an operation.
- `aluop_i`  in  4: operation code.
- `a_i`  in  WIDTH: operand A (rs1).
- `b_i`  in  WIDTH: operand B (rs2/imm); for shifts only `b_i[SHW-1:0]` is used.
- `out_valid_o`  out  1: result is valid and is held stable.
- `out_ready_i`  in  1: consumer takes the result.
- `result_o`  out  WIDTH: operation result.
- `zero_o`  out  1: `result_o == 0`; qualified by `out_valid_o`.
- `err_o`  out  1: the completed op had an unsupported aluop; qualified by `out_valid_o`.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (modulo 2^WIDTH, carry discarded)
  - 0011 SLT (signed)
  - 0100 XOR
  - 0101 SLTU
  - 0110 SRL
  - 0111 SLL
  - 1000 SRA
  - 1001–1111 unsupported: result 0, `err_o`=1.
- SLT and SLTU return 1 or 0, zero-extended to WIDTH.
- FSM states:
  - IDLE: `in_ready_o`=1. On accept (`in_valid_i & in_ready_o`):
    - non-shift op or shift amount 0: compute the result, latch it, go to DONE.
    - shift with amount ≠ 0: latch A, the op, and the amount counter; go to SHIFT.
  - SHIFT: each cycle shift the working register by 1 and decrement the counter. SRA fills with the original sign bit. On the cycle the counter reaches 1, the last shift is applied and the FSM goes to DONE.
  - DONE: `out_valid_o`=1. The result, `zero_o` and `err_o` are held. On `out_ready_i`, go to IDLE.
- Inputs are sampled only at accept. Changes to `a_i`, `b_i` or `aluop_i` after accept have no effect.
- `in_ready_o` is low in SHIFT and DONE. There is no accept in the same cycle as result hand-off; this always costs one bubble.
- Reset in any state: return to IDLE immediately. Any in-flight op is discarded and produces no output.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `result_o`=0, `zero_o`=1, `err_o`=0.
- Non-shift op, or shift by 0: `out_valid_o` rises on the cycle after accept (latency 1).
- Shift by n (1..WIDTH-1): latency 1+n cycles from accept to `out_valid_o`.
- Minimum issue interval: latency + 1 cycle when `out_ready_i` is held high.
- Back-pressure: with `out_ready_i` low, the FSM stays in DONE indefinitely and all outputs are held.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined: shifts are computed combinationally at accept, with latency 1 like all other ops. The SHIFT state and the counter are not built.
- Not defined: shifts use the bit-serial SHIFT state described above.
- The result values are identical in both builds; only latency differs.

## Structure
- Package `alu_pkg` holds:
  - aluop code localparams (`ALU_AND` … `ALU_SRA`);
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the `ALU_OP_LAST` constant used for the unsupported-code check.
- Sub-module `alu_comb_core`: a purely combinational single-cycle datapath for AND/OR/ADD/SLT/SLTU/XOR, plus the barrel shifter when `ALU_BARREL_SHIFT_EN` is defined. The top level owns the FSM, the shift register and the counter.

## Test plan
- Reset mid-SHIFT (SLL by 20, reset asserted at cycle 5) -> next cycle `in_ready_o`=1, `out_valid_o`=0; no result emitted.
- ADD, a=0xFFFFFFFF, b=0x00000001 -> one cycle later: `result_o`=0, `zero_o`=1, `err_o`=0.
- SLT, a=0x80000000, b=1 -> result 1. SLTU with the same operands -> result 0.
- SRA, a=0xF0000000, b=4 -> valid 5 cycles after accept, result 0xFF000000. SRL with the same operands -> 0x0F000000. SLL with b=0 -> latency 1, result equals a.
- Unsupported aluop 1010 -> `result_o`=0, `err_o`=1, `zero_o`=1. Hold `out_ready_i` low for 10 cycles -> outputs stable and `in_ready_o`=0 throughout.
- Back-to-back XOR ops with `out_ready_i` held high -> accepts every 2 cycles, results in issue order. Repeat with `ALU_BARREL_SHIFT_EN` defined and SLL by 31 -> latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes and FSM states.
// Used by alu_comb_core and alu_iter_unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;

    localparam logic [3:0] ALU_OP_LAST = ALU_SRA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath; barrel shifter only with ALU_BARREL_SHIFT_EN.
// Without it, shift codes pass A through (the shift-by-zero result).
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             err
);

`ifdef ALU_BARREL_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] amt;
    assign amt = b[SHW-1:0];
`endif

    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (aluop)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}},
                                $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SRL:  result = a >> amt;
            ALU_SLL:  result = a << amt;
            ALU_SRA:  result = WIDTH'($signed(a) >>> amt);
`else
            ALU_SRL,
            ALU_SLL,
            ALU_SRA:  result = a;
`endif
            default: begin
                result = '0;
                err    = (aluop > ALU_OP_LAST);
            end
        endcase
    end

endmodule

// File: rtl/alu_iter_unit.sv
// Iterative ALU with valid/ready handshake; shifts run one bit per cycle
// unless ALU_BARREL_SHIFT_EN is defined (then every op has latency 1).
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       aluop_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             err_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, core_res, shift_nxt;
    logic             err_q, core_err;
    logic             accept, start_shift;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .aluop  (aluop_i),
        .a      (a_i),
        .b      (b_i),
        .result (core_res),
        .err    (core_err)
    );

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign accept      = in_valid_i & in_ready_o;
    assign result_o    = res_q;
    assign zero_o      = (res_q == '0);
    assign err_o       = err_q;

`ifndef ALU_BARREL_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] cnt_q;
    logic [3:0]     op_q;
    logic           is_shift;

    assign is_shift = (aluop_i == ALU_SRL) ||
                      (aluop_i == ALU_SLL) ||
                      (aluop_i == ALU_SRA);
    assign start_shift = is_shift && (b_i[SHW-1:0] != '0);

    // res_q doubles as the working register; its MSB is the original sign
    always_comb begin
        shift_nxt = res_q;
        unique case (op_q)
            ALU_SLL: shift_nxt = {res_q[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_nxt = {1'b0, res_q[WIDTH-1:1]};
            default: shift_nxt = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            op_q  <= ALU_AND;
        end else if (accept) begin
            cnt_q <= b_i[SHW-1:0];
            op_q  <= aluop_i;
        end else if (state_q == SHIFT) begin
            cnt_q <= cnt_q - SHW'(1);
        end
    end
`else
    assign start_shift = 1'b0;
    assign shift_nxt   = res_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = start_shift ? SHIFT : DONE;
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
                if (cnt_q == SHW'(1))
                    state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            res_q <= start_shift ? a_i : core_res;
            err_q <= start_shift ? 1'b0 : core_err;
        end else if (state_q == SHIFT) begin
            res_q <= shift_nxt;
        end
    end

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed self-checking bench for alu_iter_unit (serial or barrel build,
// selected by ALU_BARREL_SHIFT_EN).
module tb_alu_iter_unit;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  aluop_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter_unit #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .aluop_i     (aluop_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int shift_lat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : 1 + n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_err,
                          input int exp_lat, input int hold);
        int lat;
        lat = 0;
        while (!in_ready_o && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1;
        aluop_i    = op;
        a_i        = a;
        b_i        = b;
        tick();
        // scramble inputs after accept; they must be ignored
        in_valid_i = 1'b0;
        aluop_i    = ALU_AND;
        a_i        = ~a;
        b_i        = ~b;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_zero"}, 32'(zero_o), 32'(exp_res == 32'd0));
        check({tag, "_err"}, 32'(err_o), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            tick();
            check({tag, "_hold_v"}, 32'(out_valid_o), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready_o), 32'd0);
            check({tag, "_hold_res"}, result_o, exp_res);
            check({tag, "_hold_err"}, 32'(err_o), 32'(exp_err));
            check({tag, "_hold_zero"}, 32'(zero_o), 32'(exp_res == 32'd0));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, "_done"}, 32'(out_valid_o), 32'd0);
    endtask

    logic [31:0] xa [3];
    logic [31:0] xb [3];
    int          acc [3];
    int          na, nr, nv;
    logic        rdy;

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        aluop_i     = ALU_AND;
        a_i         = 32'h0;
        b_i         = 32'h0;
        tick();
        tick();
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", 32'(zero_o), 32'd1);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // reset while an SLL by 20 is in flight
        in_valid_i = 1'b1;
        aluop_i    = ALU_SLL;
        a_i        = 32'h0000_00FF;
        b_i        = 32'd20;
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_ready", 32'(in_ready_o), 32'd1);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid_o) nv++;
        end
        check("mid_rst_no_out", 32'(nv), 32'd0);

        run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'hF000_F000, 1'b0, 1, 0);
        run_op("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00,
               32'hFFF0_FFF0, 1'b0, 1, 0);
        run_op("slt", ALU_SLT, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1, 0);
        run_op("sltu", ALU_SLTU, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1, 0);
        run_op("sra4", ALU_SRA, 32'hF000_0000, 32'd4,
               32'hFF00_0000, 1'b0, shift_lat(4), 0);
        run_op("srl4", ALU_SRL, 32'hF000_0000, 32'd4,
               32'h0F00_0000, 1'b0, shift_lat(4), 0);
        run_op("sll0", ALU_SLL, 32'h1234_5678, 32'd0,
               32'h1234_5678, 1'b0, shift_lat(0), 0);
        run_op("srl_amt_mask", ALU_SRL, 32'h8000_0000, 32'h24,
               32'h0800_0000, 1'b0, shift_lat(4), 0);
        run_op("sll31", ALU_SLL, 32'h1, 32'd31,
               32'h8000_0000, 1'b0, shift_lat(31), 0);
        run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31,
               32'hFFFF_FFFF, 1'b0, shift_lat(31), 0);
        run_op("bad1001", 4'b1001, 32'h5, 32'h3, 32'h0, 1'b1, 1, 0);
        run_op("bad1010", 4'b1010, 32'h5, 32'h3, 32'h0, 1'b1, 1, 10);

        // back-to-back XOR with the consumer always ready
        xa[0] = 32'h0000_FFFF; xb[0] = 32'h00FF_00FF;
        xa[1] = 32'h1234_5678; xb[1] = 32'h1234_5678;
        xa[2] = 32'hAAAA_AAAA; xb[2] = 32'h5555_5555;
        out_ready_i = 1'b1;
        na = 0;
        nr = 0;
        aluop_i    = ALU_XOR;
        a_i        = xa[0];
        b_i        = xb[0];
        in_valid_i = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            rdy = in_ready_o;
            tick();
            if (rdy && in_valid_i) begin
                acc[na] = cyc;
                na++;
                if (na < 3) begin
                    a_i = xa[na];
                    b_i = xb[na];
                end else begin
                    in_valid_i = 1'b0;
                end
            end
            if (out_valid_o && nr < 3) begin
                check("b2b_res", result_o, xa[nr] ^ xb[nr]);
                nr++;
            end
        end
        out_ready_i = 1'b0;
        check("b2b_accepts", 32'(na), 32'd3);
        check("b2b_results", 32'(nr), 32'd3);
        if (na == 3) begin
            check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd2);
            check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
